// File: rtl/crc_frame_appender.sv
// Forwards a serial data stream one cycle late and appends the finished CRC
// serially, producing one contiguous data+CRC frame closed by a done pulse.
module crc_frame_appender #(
    parameter int unsigned CRC_SIZE  = 32,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                enable_in,
    input  logic [CRC_SIZE-1:0] crc_in,
    output logic                frame_out,
    output logic                frame_valid,
    output logic                crc_phase,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [CNT_W-1:0]    data_count
);

    localparam int unsigned   BW       = $clog2(CRC_SIZE + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(CRC_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CRC,
        S_DONE
    } state_t;

    state_t              state;
    logic [CRC_SIZE-1:0] shift_reg;
    logic [BW-1:0]       bit_cnt;

    logic                crc_first;
    logic [CRC_SIZE-1:0] crc_rest;
    logic                sr_first;
    logic [CRC_SIZE-1:0] sr_rest;

    // The first CRC bit goes straight to frame_out on the load edge; the
    // shift register only holds the remaining bits.
    always_comb begin
        crc_first = MSB_FIRST ? crc_in[CRC_SIZE-1] : crc_in[0];
        crc_rest  = MSB_FIRST ? (crc_in << 1) : (crc_in >> 1);
        sr_first  = MSB_FIRST ? shift_reg[CRC_SIZE-1] : shift_reg[0];
        sr_rest   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_out   <= 1'b0;
            frame_valid <= 1'b0;
            crc_phase   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            data_count  <= '0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable_in) begin
                        frame_out   <= serial_in;
                        frame_valid <= 1'b1;
                        data_count  <= CNT_W'(1);
                        busy        <= 1'b1;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (enable_in) begin
                        frame_out <= serial_in;
                        if (data_count != '1) begin
                            data_count <= data_count + CNT_W'(1);
                        end
                    end else begin
                        shift_reg <= crc_rest;
                        frame_out <= crc_first;
                        crc_phase <= 1'b1;
                        bit_cnt   <= LAST_IDX;
                        state     <= S_CRC;
                    end
                end
                S_CRC: begin
                    overrun <= enable_in;
                    if (bit_cnt == '0) begin
                        frame_out   <= 1'b0;
                        frame_valid <= 1'b0;
                        crc_phase   <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        frame_out <= sr_first;
                        shift_reg <= sr_rest;
                        bit_cnt   <= bit_cnt - BW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_appender.sv
// Scoreboard bench for crc_frame_appender: an MSB-first and an LSB-first
// instance (the latter with a narrow, saturating data counter) run side by side.
module tb_crc_frame_appender;

    logic        clk;
    logic        rst;
    logic        serial_in;
    logic        enable_in;
    logic [31:0] crc_in;

    logic        fo_m, fv_m, cp_m, bz_m, dn_m, ov_m;
    logic [15:0] dc_m;
    logic        fo_l, fv_l, cp_l, bz_l, dn_l, ov_l;
    logic [3:0]  dc_l;

    crc_frame_appender #(.CRC_SIZE(32), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .enable_in(enable_in),
        .crc_in(crc_in), .frame_out(fo_m), .frame_valid(fv_m), .crc_phase(cp_m),
        .busy(bz_m), .done(dn_m), .overrun(ov_m), .data_count(dc_m)
    );

    crc_frame_appender #(.CRC_SIZE(32), .MSB_FIRST(1'b0), .CNT_W(4)) u_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .enable_in(enable_in),
        .crc_in(crc_in), .frame_out(fo_l), .frame_valid(fv_l), .crc_phase(cp_l),
        .busy(bz_l), .done(dn_l), .overrun(ov_l), .data_count(dc_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic q_m[$];
    logic q_l[$];

    int cyc = 0;
    int vcnt_m = 0, vcnt_l = 0, pcnt_m = 0, pcnt_l = 0;
    int dcnt_m = 0, dcnt_l = 0, ocnt_m = 0, ocnt_l = 0;
    int last_v_m = 0, done_cyc_m = 0, last_v_l = 0, done_cyc_l = 0;

    int b_v_m, b_v_l, b_p_m, b_p_l, b_d_m, b_d_l, b_o_m, b_o_l;

    function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] crc_step(logic [31:0] r, logic b);
        logic fb;
        fb = r[31] ^ b;
        r  = r << 1;
        if (fb) r = r ^ 32'h04C1_1DB7;
        return r;
    endfunction

    // Output monitor: every valid bit is popped from the scoreboard and compared.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (fv_m) begin
            vcnt_m++;
            last_v_m = cyc;
            if (q_m.size() == 0) check("msb_queue_underflow", 64'(q_m.size()), 64'd1);
            else check("msb_bit", 64'(fo_m), 64'(q_m.pop_front()));
        end
        if (fv_l) begin
            vcnt_l++;
            last_v_l = cyc;
            if (q_l.size() == 0) check("lsb_queue_underflow", 64'(q_l.size()), 64'd1);
            else check("lsb_bit", 64'(fo_l), 64'(q_l.pop_front()));
        end
        if (cp_m) pcnt_m++;
        if (cp_l) pcnt_l++;
        if (dn_m) begin dcnt_m++; done_cyc_m = cyc; end
        if (dn_l) begin dcnt_l++; done_cyc_l = cyc; end
        if (ov_m) ocnt_m++;
        if (ov_l) ocnt_l++;
    end

    task automatic check_all_zero(string tag);
        check({tag, "_m_out"}, 64'({fo_m, fv_m, cp_m, bz_m, dn_m, ov_m}), 64'd0);
        check({tag, "_m_cnt"}, 64'(dc_m), 64'd0);
        check({tag, "_l_out"}, 64'({fo_l, fv_l, cp_l, bz_l, dn_l, ov_l}), 64'd0);
        check({tag, "_l_cnt"}, 64'(dc_l), 64'd0);
    endtask

    task automatic drive_data(input int n, input logic [127:0] d, input bit live,
                              input logic [31:0] fixed);
        logic [31:0] r;
        logic [31:0] c;
        r = '0;
        for (int i = 0; i < n; i++) r = crc_step(r, d[n-1-i]);
        c = live ? ~r : fixed;
        for (int i = 0; i < n; i++) begin
            q_m.push_back(d[n-1-i]);
            q_l.push_back(d[n-1-i]);
        end
        for (int i = 0; i < 32; i++) begin
            q_m.push_back(c[31-i]);
            q_l.push_back(c[i]);
        end
        b_v_m = vcnt_m; b_v_l = vcnt_l; b_p_m = pcnt_m; b_p_l = pcnt_l;
        b_d_m = dcnt_m; b_d_l = dcnt_l; b_o_m = ocnt_m; b_o_l = ocnt_l;
        r = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable_in = 1'b1;
            serial_in = d[n-1-i];
            crc_in    = live ? ~r : fixed;
            r         = crc_step(r, d[n-1-i]);
        end
        @(negedge clk);
        enable_in = 1'b0;
        serial_in = 1'b0;
        crc_in    = live ? ~r : fixed;
    endtask

    task automatic finish_frame(input int n, input bit live, input logic [31:0] fixed,
                                input int ovr_start, input bit poke);
        int exp_l;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            // crc_in changes after the load edge must not reach the frame
            if (k == 1 && !live) crc_in = ~fixed;
            enable_in = (ovr_start > 0 && k >= ovr_start && k < ovr_start + 3) ||
                        (poke && k == 33);
            serial_in = 1'($urandom);
        end
        enable_in = 1'b0;
        for (int t = 0; t < 60 && dcnt_m == b_d_m; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        exp_l = (n > 15) ? 15 : n;
        check("msb_queue_left", 64'(q_m.size()), 64'd0);
        check("lsb_queue_left", 64'(q_l.size()), 64'd0);
        check("msb_valid_len", 64'(vcnt_m - b_v_m), 64'(n + 32));
        check("lsb_valid_len", 64'(vcnt_l - b_v_l), 64'(n + 32));
        check("msb_crc_phase_len", 64'(pcnt_m - b_p_m), 64'd32);
        check("lsb_crc_phase_len", 64'(pcnt_l - b_p_l), 64'd32);
        check("msb_done_pulses", 64'(dcnt_m - b_d_m), 64'd1);
        check("lsb_done_pulses", 64'(dcnt_l - b_d_l), 64'd1);
        check("msb_done_timing", 64'(done_cyc_m), 64'(last_v_m + 1));
        check("lsb_done_timing", 64'(done_cyc_l), 64'(last_v_l + 1));
        check("msb_overruns", 64'(ocnt_m - b_o_m), 64'(ovr_start > 0 ? 3 : 0));
        check("lsb_overruns", 64'(ocnt_l - b_o_l), 64'(ovr_start > 0 ? 3 : 0));
        check("msb_data_count", 64'(dc_m), 64'(n));
        check("lsb_data_count_sat", 64'(dc_l), 64'(exp_l));
        check("msb_idle_after", 64'({bz_m, fv_m, cp_m}), 64'd0);
        check("lsb_idle_after", 64'({bz_l, fv_l, cp_l}), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        serial_in = 1'b0;
        enable_in = 1'b0;
        crc_in    = '0;
        #12;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // A5 with a fixed CRC, both bit orders
        drive_data(8, 128'hA5, 1'b0, 32'hDEAD_BEEF);
        finish_frame(8, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

        // 128 ones with a live CRC-32 model; narrow counter saturates
        drive_data(128, '1, 1'b1, '0);
        finish_frame(128, 1'b1, '0, 0, 1'b0);

        // overrun pulses during the CRC phase
        drive_data(8, 128'h3C, 1'b0, 32'h1234_5678);
        finish_frame(8, 1'b0, 32'h1234_5678, 5, 1'b0);

        // single-bit frame, with enable_in poked during the done cycle
        drive_data(1, 128'h1, 1'b0, 32'h8000_0001);
        finish_frame(1, 1'b0, 32'h8000_0001, 0, 1'b1);

        // async reset in the middle of the CRC phase
        drive_data(8, 128'hC3, 1'b0, 32'hDEAD_BEEF);
        for (int t = 0; t < 100 && (pcnt_m - b_p_m) < 10; t++) @(negedge clk);
        check("crc_bit10_reached", 64'(pcnt_m - b_p_m), 64'd10);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        q_m.delete();
        q_l.delete();
        b_d_m = dcnt_m;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("no_done_on_reset", 64'(dcnt_m - b_d_m), 64'd0);

        drive_data(4, 128'h9, 1'b0, 32'hCAFE_F00D);
        finish_frame(4, 1'b0, 32'hCAFE_F00D, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
